// File: rtl/response_handler_pkg.sv
// ============================================================
// response_handler_pkg: shared state encoding and byte width. Rev 1.0
// ============================================================
`default_nettype none

package response_handler_pkg;

  localparam int unsigned C_BYTE_W = 8;

  typedef logic [C_BYTE_W-1:0] byte_t;

  // Encoding is visible on debug_state and decoded by the transmit path.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SEND_CODE = 2'b01,
    SEND_DATA = 2'b10,
    DONE      = 2'b11
  } state_e;

endpackage

`default_nettype wire

// File: rtl/response_handler.sv
// ============================================================
// response_handler: two-byte code/data response sequencer. Rev 1.0
// ============================================================
`default_nettype none

module response_handler
  import response_handler_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [C_BYTE_W-1:0] response_code,
  input  logic [C_BYTE_W-1:0] response_data,
  output logic                has_response,
  output logic [C_BYTE_W-1:0] response,
  output logic [1:0]          debug_state
);

  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  byte_t      code_q, code_d;
  byte_t      data_q, data_d;
  byte_t      response_q, response_d;
  logic       has_response_q, has_response_d;
  logic       w_hold_done;

  // cnt_q counts completed cycles in the current state, so the last hold cycle is HOLD_CYCLES-1.
  assign w_hold_done = (cnt_q >= C_HOLD_LAST);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + 8'd1;
    code_d         = code_q;
    data_d         = data_q;
    has_response_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (enable) begin
          state_d        = SEND_CODE;
          code_d         = response_code;
          has_response_d = 1'b1;
        end
      end
      SEND_CODE: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (w_hold_done) begin
          state_d        = SEND_DATA;
          data_d         = response_data;
          has_response_d = 1'b1;
          cnt_d          = 8'd0;
        end
      end
      SEND_DATA: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (w_hold_done) begin
          state_d = DONE;
          cnt_d   = 8'd0;
        end
      end
      DONE: begin
        cnt_d = 8'd0;
        if (!enable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // The presented byte follows the state being entered, so it is valid on the transition edge.
    case (state_d)
      SEND_CODE: response_d = code_d;
      SEND_DATA: response_d = data_d;
      default:   response_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      code_q         <= '0;
      data_q         <= '0;
      response_q     <= '0;
      has_response_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      code_q         <= code_d;
      data_q         <= data_d;
      response_q     <= response_d;
      has_response_q <= has_response_d;
    end
  end

  assign has_response = has_response_q;
  assign response     = response_q;
  assign debug_state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_response_handler.sv
// ============================================================
// tb_response_handler: HOLD_CYCLES=1 and =3 instances against a sequence-position model. Rev 1.0
// ============================================================
`default_nettype none

module tb_response_handler;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] response_code;
  logic [7:0] response_data;

  logic       has_r  [2];
  logic [7:0] resp_r [2];
  logic [1:0] dbg_r  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: position k counts edges since the start edge; the code occupies k<H, the data H<=k<2H.
  int         hold  [2] = '{1, 3};
  int         mph   [2];
  int         k     [2];
  logic [7:0] c_lat [2];
  logic [7:0] d_lat [2];
  logic       e_hs  [2];
  logic [7:0] e_rs  [2];
  logic [1:0] e_st  [2];

  always #5 clock = ~clock;

  response_handler #(.HOLD_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable),
    .response_code(response_code), .response_data(response_data),
    .has_response(has_r[0]), .response(resp_r[0]), .debug_state(dbg_r[0])
  );

  response_handler #(.HOLD_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .enable(enable),
    .response_code(response_code), .response_data(response_data),
    .has_response(has_r[1]), .response(resp_r[1]), .debug_state(dbg_r[1])
  );

  task automatic set_exp(input int i, input logic hs, input logic [7:0] rs, input logic [1:0] st);
    e_hs[i] = hs;
    e_rs[i] = rs;
    e_st[i] = st;
  endtask

  task automatic model_edge(input int i, input logic rst, input logic en,
                            input logic [7:0] c, input logic [7:0] d);
    if (rst) begin
      mph[i] = 0;
      set_exp(i, 1'b0, 8'h00, 2'd0);
    end else if (mph[i] == 0) begin
      if (en) begin
        mph[i]   = 1;
        k[i]     = 0;
        c_lat[i] = c;
        set_exp(i, 1'b1, c, 2'd1);
      end else begin
        set_exp(i, 1'b0, 8'h00, 2'd0);
      end
    end else if (mph[i] == 1) begin
      if (!en) begin
        mph[i] = 0;
        set_exp(i, 1'b0, 8'h00, 2'd0);
      end else begin
        k[i] = k[i] + 1;
        if (k[i] < hold[i]) begin
          set_exp(i, 1'b0, c_lat[i], 2'd1);
        end else if (k[i] == hold[i]) begin
          d_lat[i] = d;
          set_exp(i, 1'b1, d, 2'd2);
        end else if (k[i] < 2 * hold[i]) begin
          set_exp(i, 1'b0, d_lat[i], 2'd2);
        end else begin
          mph[i] = 2;
          set_exp(i, 1'b0, 8'h00, 2'd3);
        end
      end
    end else begin
      if (!en) begin
        mph[i] = 0;
        set_exp(i, 1'b0, 8'h00, 2'd0);
      end else begin
        set_exp(i, 1'b0, 8'h00, 2'd3);
      end
    end
  endtask

  task automatic step(input logic rst, input logic en, input logic [7:0] c, input logic [7:0] d);
    reset         = rst;
    enable        = en;
    response_code = c;
    response_data = d;
    @(posedge clock);
    for (int i = 0; i < 2; i++) model_edge(i, rst, en, c, d);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      assert (has_r[i] === e_hs[i]) else begin
        n_bad++;
        $error("FAIL has_response[H=%0d] observed=%b expected=%b", hold[i], has_r[i], e_hs[i]);
      end
      n_cmp++;
      assert (resp_r[i] === e_rs[i]) else begin
        n_bad++;
        $error("FAIL response[H=%0d] observed=%h expected=%h", hold[i], resp_r[i], e_rs[i]);
      end
      n_cmp++;
      assert (dbg_r[i] === e_st[i]) else begin
        n_bad++;
        $error("FAIL debug_state[H=%0d] observed=%b expected=%b", hold[i], dbg_r[i], e_st[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mph[i] = 0; k[i] = 0; c_lat[i] = 8'h00; d_lat[i] = 8'h00;
    end
    // Reset state
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    // Nominal: code 11 then data 20
    step(1'b0, 1'b1, 8'h11, 8'h99);
    step(1'b0, 1'b1, 8'h77, 8'h20);
    step(1'b0, 1'b1, 8'h77, 8'h20);
    // Hold in DONE, then release
    repeat (5) step(1'b0, 1'b1, 8'h44, 8'h55);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    // Re-arm with 22 / 33
    step(1'b0, 1'b1, 8'h22, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'h33);
    step(1'b0, 1'b1, 8'h00, 8'h33);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    // Abort during SEND_CODE of the HOLD=3 instance
    step(1'b0, 1'b1, 8'h6C, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'hEE);
    step(1'b0, 1'b0, 8'h00, 8'hEE);
    step(1'b0, 1'b0, 8'h00, 8'hEE);
    // Reset while the HOLD=3 instance is in SEND_DATA, then restart
    step(1'b0, 1'b1, 8'h81, 8'h00);
    repeat (3) step(1'b0, 1'b1, 8'h00, 8'h18);
    step(1'b1, 1'b1, 8'h00, 8'h18);
    step(1'b0, 1'b1, 8'h3C, 8'h00);
    step(1'b0, 1'b1, 8'h00, 8'hC3);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    // HOLD=3: A5 then 5A, data input changing during the hold
    step(1'b0, 1'b1, 8'hA5, 8'h00);
    step(1'b0, 1'b1, 8'h01, 8'h02);
    step(1'b0, 1'b1, 8'h03, 8'h04);
    step(1'b0, 1'b1, 8'h05, 8'h5A);
    step(1'b0, 1'b1, 8'h06, 8'hFF);
    step(1'b0, 1'b1, 8'h07, 8'h0F);
    step(1'b0, 1'b1, 8'h08, 8'hF0);
    step(1'b0, 1'b0, 8'h00, 8'h00);
    // Randomized traffic, mostly enabled, occasional aborts and resets
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
           8'($urandom), 8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
